trng_ctrl: RTL and testbench
============================

TRNG_CTRL -- requirements
Module: trng_ctrl

Interface
REQ-001 Parameter WARMUP_CYCLES, 64, cycles the ring oscillators run after enable before any sample is taken; legal values >= 1.
REQ-002 Parameter SAMPLE_DIV, 4, clock cycles per raw-bit sample; legal values >= 1.
REQ-003 Parameter REP_LIMIT, 32, consecutive identical samples that trigger a health failure; legal values >= 2.
REQ-004 Parameter WORD_WIDTH, 32, bits per output word; legal values >= 2.
REQ-005 Port clock  input  1  single system clock; all logic on posedge clock.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port run  input  1  level request for continuous random-word generation.
REQ-008 Port raw_bit  input  1  combined oscillator bit, already registered in the clock domain.
REQ-009 Port clear_fail  input  1  single-cycle pulse that clears a latched health failure.
REQ-010 Port ro_enable  output  1  enable to the ring-oscillator combiner.
REQ-011 Port word_data  output  WORD_WIDTH  assembled random word.
REQ-012 Port word_valid  output  1  word_data is valid; valid/ready handshake.
REQ-013 Port word_ready  input  1  consumer accepts word_data.
REQ-014 Port health_fail  output  1  sticky repetition-count failure flag.
REQ-015 Port busy  output  1  high in any state other than IDLE and FAIL.

Function
REQ-016 The block SHALL drive all outputs from registers.
REQ-017 The block SHALL implement the states IDLE, WARMUP, COLLECT, HOLD and FAIL.
REQ-018 In IDLE, ro_enable=0 and word_valid=0; when run=1 is sampled, the next state SHALL be WARMUP, with ro_enable=1 from that cycle.
REQ-019 WARMUP SHALL last exactly WARMUP_CYCLES cycles, then go to COLLECT; it clears the bit count, the divider and the run-length counter.
REQ-020 In COLLECT, sample k (k=1..WORD_WIDTH) SHALL be taken on the (k*SAMPLE_DIV)-th cycle in COLLECT.
REQ-021 On each sample, the shift register SHALL shift left with raw_bit entering bit 0, so the first sample ends at the MSB.
REQ-022 After sample WORD_WIDTH, the block SHALL load word_data and go to HOLD with word_valid=1 on the next cycle.
REQ-023 Latency from run sampled in IDLE to word_valid SHALL be 1+WARMUP_CYCLES+WORD_WIDTH*SAMPLE_DIV cycles.
REQ-024 In HOLD, sampling SHALL pause while ro_enable stays 1, and word_data and word_valid SHALL stay stable until word_valid&&word_ready.
REQ-025 On acceptance, the next state SHALL be COLLECT (bit count=0, divider=0) if run=1, else IDLE; word_valid drops the cycle after acceptance.
REQ-026 word_data SHALL retain the last word after acceptance, until overwritten.
REQ-027 run=0 in WARMUP or COLLECT SHALL cause IDLE next cycle, discarding the partial word.
REQ-028 run=0 in HOLD SHALL NOT drop the pending word.
REQ-029 Run length SHALL be set to 1 on a sample differing from the previous sample (or on the first sample after WARMUP), else increment saturating at REP_LIMIT.
REQ-030 Run length SHALL persist across word boundaries.
REQ-031 When run length reaches REP_LIMIT, the next state SHALL be FAIL: health_fail=1, ro_enable=0, word_valid=0.
REQ-032 FAIL SHALL take priority over word completion on the same sample; that word is discarded.
REQ-033 FAIL SHALL be left only by clear_fail=1, going to IDLE with health_fail=0; clear_fail in any other state SHALL be ignored.
REQ-034 Counter widths SHALL be $clog2-sized with no overflow at the maximum parameter values.

Reset
REQ-035 reset_n=0 SHALL immediately force state IDLE and set ro_enable, word_valid, health_fail, busy, word_data and all counters to 0, including when reset occurs mid-WARMUP, mid-COLLECT or in HOLD.
REQ-036 After reset_n rises, the block SHALL act only on the first subsequent clock edge.

Verification (WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=8, WORD_WIDTH=8)
REQ-037 run=1, raw_bit alternating per sample starting at 1, word_ready=1 -> word_valid rises 21 cycles after run is sampled with word_data=0xAA; the next word follows 16 cycles after acceptance.
REQ-038 Hold word_ready=0 for 10 cycles in HOLD -> word_valid and word_data stay stable with no samples taken; on word_ready=1, one word is accepted and COLLECT resumes.
REQ-039 raw_bit stuck at 1 -> on the 8th sample health_fail=1, ro_enable=0 and no word_valid; clear_fail pulse -> IDLE with health_fail=0.
REQ-040 Drop run after 3 samples in COLLECT -> IDLE next cycle, ro_enable=0, no word_valid; reassert run -> full 4-cycle warmup before sampling.
REQ-041 Assert reset_n=0 in HOLD -> word_valid, ro_enable and word_data are 0 without a clock edge.
REQ-042 Pulse clear_fail in COLLECT -> no state change, and the word completes normally.

Source files
------------

// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG controller. It warms the oscillators up, samples raw_bit
// every SAMPLE_DIV cycles into a word, and runs a repetition-count health test.
module trng_ctrl #(
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 32,
    parameter int WORD_WIDTH    = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  raw_bit,
    input  logic                  clear_fail,
    output logic                  ro_enable,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  health_fail,
    output logic                  busy
);

    // Every counter is sized to hold its limit value, so no parameter value can wrap it
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int BIT_W  = $clog2(WORD_WIDTH + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, WARMUP, COLLECT, HOLD, FAIL} state_t;

    state_t                state;
    logic [WARM_W-1:0]     warm_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [REP_W-1:0]      rep_cnt;
    logic [REP_W-1:0]      rep_next;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] shifted;
    logic                  prev_bit;
    logic                  first_smp;
    logic                  sample_tick;

    always_comb begin
        sample_tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
        shifted     = {shreg[WORD_WIDTH-2:0], raw_bit};
        if (first_smp || (raw_bit != prev_bit))
            rep_next = REP_W'(1);
        else if (rep_cnt == REP_W'(REP_LIMIT))
            rep_next = rep_cnt;
        else
            rep_next = rep_cnt + REP_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ro_enable   <= 1'b0;
            word_valid  <= 1'b0;
            health_fail <= 1'b0;
            busy        <= 1'b0;
            word_data   <= '0;
            shreg       <= '0;
            warm_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            prev_bit    <= 1'b0;
            first_smp   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= WARMUP;
                        ro_enable <= 1'b1;
                        busy      <= 1'b1;
                        warm_cnt  <= '0;
                    end
                end
                WARMUP: begin
                    if (!run) begin
                        state     <= IDLE;
                        ro_enable <= 1'b0;
                        busy      <= 1'b0;
                    end else if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
                        state     <= COLLECT;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        rep_cnt   <= '0;
                        first_smp <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end
                COLLECT: begin
                    if (!run) begin
                        state     <= IDLE;
                        ro_enable <= 1'b0;
                        busy      <= 1'b0;
                    end else if (sample_tick) begin
                        div_cnt   <= '0;
                        shreg     <= shifted;
                        prev_bit  <= raw_bit;
                        first_smp <= 1'b0;
                        rep_cnt   <= rep_next;
                        // A health failure wins over a word completing on the same sample
                        if (rep_next == REP_W'(REP_LIMIT)) begin
                            state       <= FAIL;
                            ro_enable   <= 1'b0;
                            busy        <= 1'b0;
                            health_fail <= 1'b1;
                        end else if (bit_cnt == BIT_W'(WORD_WIDTH - 1)) begin
                            state      <= HOLD;
                            word_data  <= shifted;
                            word_valid <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (run) begin
                            state   <= COLLECT;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            state     <= IDLE;
                            ro_enable <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                FAIL: begin
                    if (clear_fail) begin
                        state       <= IDLE;
                        health_fail <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ro_enable  <= 1'b0;
                    word_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl: a table of words streamed back-to-back, plus
// hand-written sequences for abort, health failure, clear_fail and reset in HOLD.
module tb_trng_ctrl;

    localparam int W  = 4;
    localparam int D  = 2;
    localparam int R  = 8;
    localparam int WW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          run = 1'b0;
    logic          raw_bit = 1'b0;
    logic          clear_fail = 1'b0;
    logic          word_ready = 1'b0;
    logic          ro_enable;
    logic          word_valid;
    logic          health_fail;
    logic          busy;
    logic [WW-1:0] word_data;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [WW-1:0] pat;
        int            hold;
        logic [WW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    trng_ctrl #(
        .WARMUP_CYCLES(W),
        .SAMPLE_DIV   (D),
        .REP_LIMIT    (R),
        .WORD_WIDTH   (WW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .raw_bit    (raw_bit),
        .clear_fail (clear_fail),
        .ro_enable  (ro_enable),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .health_fail(health_fail),
        .busy       (busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge right after COLLECT is entered.
    task automatic warmup();
        run = 1'b1;
        @(negedge clock);
        chk1("warm_ro", ro_enable, 1'b1);
        chk1("warm_busy", busy, 1'b1);
        chk1("warm_valid", word_valid, 1'b0);
        repeat (W) @(negedge clock);
        chk1("collect_ro", ro_enable, 1'b1);
    endtask

    // Feeds one sample per SAMPLE_DIV cycles, MSB first; optional clear_fail pulse at sample clr_at.
    task automatic collect(input logic [WW-1:0] pat, input logic [WW-1:0] exp, input int clr_at);
        for (int k = 0; k < WW; k++) begin
            raw_bit = pat[WW-1-k];
            if (k == clr_at) clear_fail = 1'b1;
            @(negedge clock);
            clear_fail = 1'b0;
            if (k == WW - 1) chk1("valid_early", word_valid, 1'b0);
            @(negedge clock);
        end
        chk1("word_valid", word_valid, 1'b1);
        chkw("word_data", word_data, exp);
        chk1("hold_ro", ro_enable, 1'b1);
        chk1("hold_health", health_fail, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'hAA, 0,  8'hAA};
        vecs[1] = '{8'h55, 10, 8'h55};
        vecs[2] = '{8'h33, 3,  8'h33};
        vecs[3] = '{8'hC3, 0,  8'hC3};
        vecs[4] = '{8'h0F, 1,  8'h0F};
        vecs[5] = '{8'h96, 2,  8'h96};

        #1 reset_n = 1'b0;
        #2;
        chk1("rst_ro", ro_enable, 1'b0);
        chk1("rst_valid", word_valid, 1'b0);
        chk1("rst_health", health_fail, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_data", word_data, 8'h00);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk1("idle_ro", ro_enable, 1'b0);

        // Back-to-back words; each acceptance goes straight back to COLLECT
        warmup();
        for (int i = 0; i < 6; i++) begin
            collect(vecs[i].pat, vecs[i].exp, -1);
            for (int h = 0; h < vecs[i].hold; h++) begin
                @(negedge clock);
                chk1("hold_valid", word_valid, 1'b1);
                chkw("hold_data", word_data, vecs[i].exp);
                chk1("hold_ro_stall", ro_enable, 1'b1);
            end
            word_ready = 1'b1;
            @(negedge clock);
            word_ready = 1'b0;
            chk1("acc_valid", word_valid, 1'b0);
            chkw("acc_data_kept", word_data, vecs[i].exp);
            chk1("acc_busy", busy, 1'b1);
        end

        // run dropped in HOLD keeps the pending word
        collect(8'h5A, 8'h5A, -1);
        run = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk1("hold_norun_valid", word_valid, 1'b1);
            chkw("hold_norun_data", word_data, 8'h5A);
        end
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
        chk1("acc_idle_valid", word_valid, 1'b0);
        chk1("acc_idle_ro", ro_enable, 1'b0);
        chk1("acc_idle_busy", busy, 1'b0);

        // Abort after three samples, then a fresh full warmup
        warmup();
        for (int k = 0; k < 3; k++) begin
            raw_bit = k[0];
            repeat (D) @(negedge clock);
        end
        run = 1'b0;
        @(negedge clock);
        chk1("abort_ro", ro_enable, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_valid", word_valid, 1'b0);
        @(negedge clock);
        chk1("abort_idle_ro", ro_enable, 1'b0);
        warmup();
        // clear_fail in COLLECT must be ignored
        collect(8'hA5, 8'hA5, 3);
        run = 1'b0;
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
        chk1("acc2_ro", ro_enable, 1'b0);

        // Stuck-at-1: eighth sample trips the health test and discards the word
        warmup();
        raw_bit = 1'b1;
        repeat (7 * D) @(negedge clock);
        chk1("pre_fail_health", health_fail, 1'b0);
        chk1("pre_fail_ro", ro_enable, 1'b1);
        repeat (D) @(negedge clock);
        chk1("fail_health", health_fail, 1'b1);
        chk1("fail_ro", ro_enable, 1'b0);
        chk1("fail_valid", word_valid, 1'b0);
        chk1("fail_busy", busy, 1'b0);
        repeat (3) @(negedge clock);
        chk1("fail_sticky", health_fail, 1'b1);
        chk1("fail_sticky_ro", ro_enable, 1'b0);
        clear_fail = 1'b1;
        @(negedge clock);
        clear_fail = 1'b0;
        run = 1'b0;
        chk1("clear_health", health_fail, 1'b0);
        chk1("clear_busy", busy, 1'b0);
        chk1("clear_ro", ro_enable, 1'b0);
        @(negedge clock);
        chk1("clear_idle_ro", ro_enable, 1'b0);

        // Asynchronous reset while a word is held
        warmup();
        collect(8'h3C, 8'h3C, -1);
        #2 reset_n = 1'b0;
        #1;
        chk1("arst_valid", word_valid, 1'b0);
        chk1("arst_ro", ro_enable, 1'b0);
        chkw("arst_data", word_data, 8'h00);
        chk1("arst_busy", busy, 1'b0);
        run = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk1("post_rst_ro", ro_enable, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
